// File: rtl/lsu_mem_port.sv
// Load/store port: decodes one core request at a time, drives a grant/rvalid
// memory handshake and returns a single-cycle response with formatted data or error.
module lsu_mem_port #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    localparam int CW = $clog2(TIMEOUT_CYCLES);
    // The counter value in the last permitted REQ/WAIT cycle
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 2);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          lat_we;
    logic [2:0]    lat_f3;
    logic [1:0]    lat_off;

    logic          legal;
    logic          misaligned;
    logic [3:0]    be_dec;
    logic [31:0]   wdata_dec;
    logic [31:0]   lane;
    logic [31:0]   load_fmt;
    logic          timeout;

    assign req_ready = (state == S_IDLE);
    assign timeout   = (cnt == CNT_LAST);

    always_comb begin
        legal      = 1'b0;
        misaligned = 1'b0;
        be_dec     = 4'b1111;
        wdata_dec  = req_wdata;
        if (req_we)
            legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
        else
            legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
                    (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
        case (req_funct3[1:0])
            2'b00: begin
                be_dec    = 4'b0001 << req_addr[1:0];
                wdata_dec = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                misaligned = req_addr[0];
                be_dec     = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_dec  = {2{req_wdata[15:0]}};
            end
            default: begin
                misaligned = (req_addr[1:0] != 2'b00);
                be_dec     = 4'b1111;
                wdata_dec  = req_wdata;
            end
        endcase
    end

    always_comb begin
        lane     = mem_rdata >> {lat_off, 3'b000};
        load_fmt = lane;
        case (lat_f3)
            3'b000:  load_fmt = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_fmt = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_fmt = {24'h0, lane[7:0]};
            3'b101:  load_fmt = {16'h0, lane[15:0]};
            default: load_fmt = lane;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            lat_we     <= 1'b0;
            lat_f3     <= 3'b000;
            lat_off    <= 2'b00;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'h0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'h0;
            mem_be     <= 4'h0;
            mem_wdata  <= 32'h0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        lat_we  <= req_we;
                        lat_f3  <= req_funct3;
                        lat_off <= req_addr[1:0];
                        if (!legal || misaligned) begin
                            state      <= S_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'h0;
                        end else begin
                            state     <= S_REQ;
                            cnt       <= '0;
                            mem_req   <= 1'b1;
                            mem_we    <= req_we;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_be    <= be_dec;
                            mem_wdata <= wdata_dec;
                        end
                    end
                end
                S_REQ: begin
                    cnt <= cnt + CW'(1);
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        if (lat_we) begin
                            state      <= S_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b0;
                            resp_rdata <= 32'h0;
                        end else begin
                            state <= S_WAIT;
                        end
                    end else if (timeout) begin
                        mem_req    <= 1'b0;
                        state      <= S_RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= 32'h0;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt + CW'(1);
                    if (mem_rvalid) begin
                        state      <= S_RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= load_fmt;
                    end else if (timeout) begin
                        state      <= S_RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= 32'h0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
